// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues imem requests at the PC, tags in-flight fetches with an epoch,
// buffers in-order responses for decode, and handles halt drain and response timeout.
module fetch_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_addr,
  input  logic        i_redirect,
  output logic        o_pc_hold,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_halt_req,
  output logic        o_halted,
  output logic        o_fetch_err
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [7:0]    TMO_VAL  = 8'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED, S_ERR} state_e;
  state_e state_q, state_d;

  logic [31:0]                tag_addr_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_ep_q;
  logic [PW-1:0]              tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]              out_q, out_d;

  logic [31:0]   buf_inst_q [MAX_OUTSTANDING];
  logic [31:0]   buf_pc_q   [MAX_OUTSTANDING];
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  logic       epoch_q, epoch_d;
  logic [7:0] timer_q, timer_d;

  logic fire, rsp, hit, pop, push, overflow, proto_err, tmo;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both in-flight and buffered entries so a response always has a slot.
  assign o_imem_req  = (state_q == S_RUN) &&
                       (({1'b0, out_q} + {1'b0, buf_cnt_q}) < {1'b0, CNT_MAX});
  assign o_imem_addr = i_pc_addr;
  assign fire        = o_imem_req & i_imem_gnt;
  assign rsp         = i_imem_rvalid & (out_q != '0);
  assign hit         = rsp & (tag_ep_q[tag_rd_q] == epoch_q);

  assign o_inst_valid = (buf_cnt_q != '0) && (state_q != S_ERR);
  assign pop          = o_inst_valid & i_inst_ready;
  assign overflow     = hit && (buf_cnt_q == CNT_MAX) && !pop;
  assign push         = hit & !overflow & !i_redirect;
  assign proto_err    = (i_imem_rvalid && (out_q == '0)) || overflow;
  assign tmo          = (timer_q == TMO_VAL);

  assign o_pc_hold   = (state_q == S_ERR) | (!fire & !i_redirect);
  assign o_halted    = (state_q == S_HALTED);
  assign o_fetch_err = (state_q == S_ERR);
  assign o_inst      = o_inst_valid ? buf_inst_q[buf_rd_q] : '0;
  assign o_inst_pc   = o_inst_valid ? buf_pc_q[buf_rd_q]   : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_RUN;
      S_RUN:    if (i_halt_req) state_d = S_DRAIN;
      S_DRAIN:  if (out_q == '0) state_d = S_HALTED;
      S_HALTED: if (!i_halt_req) state_d = S_RUN;
      default:  state_d = S_ERR;
    endcase
    if (proto_err || tmo) state_d = S_ERR;
  end

  always_comb begin
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    out_d     = out_q;
    buf_wr_d  = buf_wr_q;
    buf_rd_d  = buf_rd_q;
    buf_cnt_d = buf_cnt_q;
    epoch_d   = epoch_q;
    timer_d   = '0;
    if (fire) tag_wr_d = ptr_inc(tag_wr_q);
    if (rsp)  tag_rd_d = ptr_inc(tag_rd_q);
    case ({fire, rsp})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if ((out_q != '0) && !i_imem_rvalid) timer_d = timer_q + 8'd1;
    // Redirect flushes the buffer; in-flight tags stay so stale responses drain and drop.
    if (i_redirect) begin
      epoch_d   = ~epoch_q;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (push) buf_wr_d = ptr_inc(buf_wr_q);
      if (pop)  buf_rd_d = ptr_inc(buf_rd_q);
      case ({push, pop})
        2'b10:   buf_cnt_d = buf_cnt_q + CW'(1);
        2'b01:   buf_cnt_d = buf_cnt_q - CW'(1);
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      tag_ep_q  <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      out_q     <= '0;
      buf_wr_q  <= '0;
      buf_rd_q  <= '0;
      buf_cnt_q <= '0;
      epoch_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      if (fire) tag_ep_q[tag_wr_q] <= epoch_q;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      out_q     <= out_d;
      buf_wr_q  <= buf_wr_d;
      buf_rd_q  <= buf_rd_d;
      buf_cnt_q <= buf_cnt_d;
      epoch_q   <= epoch_d;
      timer_q   <= timer_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fire) tag_addr_q[tag_wr_q] <= i_pc_addr;
    if (push) begin
      buf_inst_q[buf_wr_q] <= i_imem_rdata;
      buf_pc_q[buf_wr_q]   <= tag_addr_q[tag_rd_q];
    end
  end

endmodule
